// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl: runs NUM_STAGES datapath stages back to back, with a per-stage WAIT timeout.
// Define FC_SEQ_PERF_EN to build the pass-cycle counter behind pass_cycles_o.
module fc_seq_ctrl #(
   parameter int unsigned NUM_STAGES     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned STG_W          = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  clear_i,
   input  logic [NUM_STAGES-1:0] stage_done_i,
   output logic [NUM_STAGES-1:0] stage_start_o,
   output logic [STG_W-1:0]      stage_idx_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [STG_W-1:0]      err_stage_o,
   output logic [31:0]           pass_cycles_o
);

   localparam int unsigned WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [STG_W-1:0]  LAST_STG  = STG_W'(NUM_STAGES - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_FINISH,
      S_ERROR
   } state_t;

   state_t                state_q;
   logic [STG_W-1:0]      stage_q;
   logic [STG_W-1:0]      stage_d;
   logic [STG_W-1:0]      err_stage_q;
   logic [WCNT_W-1:0]     wait_q;
   logic [NUM_STAGES-1:0] stage_start_q;
   logic                  done_q;
   logic                  error_q;
   logic                  active_done;

   assign stage_d     = stage_q + STG_W'(1);
   assign active_done = stage_done_i[stage_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         stage_q       <= '0;
         wait_q        <= '0;
         stage_start_q <= '0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         err_stage_q   <= '0;
      end else begin
         stage_start_q <= '0;
         done_q        <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q       <= S_ISSUE;
                  stage_q       <= '0;
                  stage_start_q <= NUM_STAGES'(1);
               end
            end
            S_ISSUE: begin
               if (abort_i) begin
                  state_q <= S_IDLE;
                  stage_q <= '0;
               end else begin
                  state_q <= S_WAIT;
                  wait_q  <= '0;
               end
            end
            S_WAIT: begin
               // abort beats done, done beats timeout
               if (abort_i) begin
                  state_q <= S_IDLE;
                  stage_q <= '0;
               end else if (active_done) begin
                  if (stage_q == LAST_STG) begin
                     state_q <= S_FINISH;
                     done_q  <= 1'b1;
                  end else begin
                     state_q       <= S_ISSUE;
                     stage_q       <= stage_d;
                     stage_start_q <= NUM_STAGES'(1) << stage_d;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  state_q     <= S_ERROR;
                  error_q     <= 1'b1;
                  err_stage_q <= stage_q;
               end else begin
                  wait_q <= wait_q + WCNT_W'(1);
               end
            end
            S_FINISH: begin
               state_q <= S_IDLE;
               stage_q <= '0;
            end
            S_ERROR: begin
               if (clear_i) begin
                  state_q     <= S_IDLE;
                  stage_q     <= '0;
                  error_q     <= 1'b0;
                  err_stage_q <= '0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               stage_q <= '0;
            end
         endcase
      end
   end

   assign busy_o        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_FINISH);
   assign stage_start_o = stage_start_q;
   assign stage_idx_o   = stage_q;
   assign done_o        = done_q;
   assign error_o       = error_q;
   assign err_stage_o   = err_stage_q;

`ifdef FC_SEQ_PERF_EN
   logic [31:0] perf_q;
   logic [31:0] perf_inc;
   logic [31:0] pass_cycles_q;

   assign perf_inc = (perf_q == '1) ? perf_q : perf_q + 32'd1;

   // perf_q holds the busy cycles already elapsed, so it reads 0 during stage-0 ISSUE
   // and the FINISH cycle itself is added when the result is captured.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_q        <= '0;
         pass_cycles_q <= '0;
      end else begin
         if ((state_q == S_IDLE) && start_i) begin
            perf_q <= '0;
         end else if (busy_o) begin
            perf_q <= perf_inc;
         end
         if ((state_q == S_FINISH) && !abort_i) begin
            pass_cycles_q <= perf_inc;
         end
      end
   end

   assign pass_cycles_o = pass_cycles_q;
`else
   assign pass_cycles_o = '0;
`endif

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Self-checking bench for fc_seq_ctrl: randomized per-stage done delays checked
// cycle by cycle against a schedule computed from the stage delays.
module tb_fc_seq_ctrl;

   localparam int N = 3;
   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        clear;
   logic [2:0]  done_in;
   logic [2:0]  start_o;
   logic [1:0]  idx_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic [1:0]  err_o;
   logic [31:0] pass_o;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pass = '0;

   always #5 clk = ~clk;

   fc_seq_ctrl #(
      .NUM_STAGES    (N),
      .TIMEOUT_CYCLES(T),
      .STG_W         (2)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .clear_i      (clear),
      .stage_done_i (done_in),
      .stage_start_o(start_o),
      .stage_idx_o  (idx_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .err_stage_o  (err_o),
      .pass_cycles_o(pass_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] observed();
      return {22'd0, start_o, done_o, busy_o, error_o, idx_o, err_o};
   endfunction

   // Expected {stage_start, done, busy, error, idx, err_stage} for cycle c of a pass
   // (cycle 0 = stage-0 start pulse). d[k] = done delay after stage k's start, 0 = never.
   function automatic logic [31:0] model(input int c, input int d[3], input int abort_at);
      int t;
      t = 0;
      if (abort_at >= 0 && c > abort_at) return '0;
      for (int k = 0; k < N; k++) begin
         if (c == t) return {22'd0, 3'(1 << k), 1'b0, 1'b1, 1'b0, 2'(k), 2'd0};
         if (d[k] == 0) begin
            if (c <= t + T) return {22'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'(k), 2'd0};
            return {22'd0, 3'd0, 1'b0, 1'b0, 1'b1, 2'(k), 2'(k)};
         end
         if (c <= t + d[k]) return {22'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'(k), 2'd0};
         t = t + d[k] + 1;
      end
      if (c == t) return {22'd0, 3'd0, 1'b1, 1'b1, 1'b0, 2'(N - 1), 2'd0};
      return '0;
   endfunction

   task automatic run_pass(input string name, input int d[3], input int abort_at,
                           input bit poke_finish, input int rst_at);
      int          ti[3];
      int          t;
      int          to_stage;
      int          fin;
      int          last;
      int          sum;
      logic [31:0] expv;
      t = 0;
      to_stage = -1;
      sum = 0;
      for (int k = 0; k < N; k++) begin
         ti[k] = t;
         if (to_stage < 0) begin
            if (d[k] == 0) to_stage = k;
            else begin
               t = t + d[k] + 1;
               sum = sum + d[k];
            end
         end
      end
      fin = t;
      if (rst_at >= 0)        last = rst_at;
      else if (abort_at >= 0) last = abort_at + 3;
      else if (to_stage >= 0) last = ti[to_stage] + T + 6;
      else                    last = fin + 3;

      check({name, "/idle_before"}, observed(), '0);
      start = 1'b1;
      tick();
      start = 1'b0;

      for (int c = 0; c <= last; c++) begin
         expv = model(c, d, abort_at);
         check($sformatf("%s/c%0d", name, c), observed(), expv);
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            check({name, "/rst_outputs"}, observed(), '0);
            check({name, "/rst_pass"}, pass_o, '0);
            exp_pass = '0;
            tick();
            rst = 1'b0;
            break;
         end
         done_in = '0;
         for (int k = 0; k < N; k++) begin
            if (to_stage < 0 || k <= to_stage) begin
               if (c == ti[k]) begin
                  done_in = 3'($urandom) | 3'(1 << k);
               end else if (c > ti[k] && (d[k] == 0 || c <= ti[k] + d[k])) begin
                  done_in = 3'($urandom) & ~3'(1 << k);
                  if (d[k] != 0 && c == ti[k] + d[k]) done_in = done_in | 3'(1 << k);
               end
            end
         end
         start = (expv[4] || expv[5]) && ($urandom_range(0, 3) == 0);
         if (poke_finish && c == fin && to_stage < 0 && abort_at < 0) start = 1'b1;
         abort = (c == abort_at) || (expv[4] && ($urandom_range(0, 1) == 0));
         tick();
      end
      done_in = '0;
      start   = 1'b0;
      abort   = 1'b0;
      if (rst_at >= 0) return;

      if (to_stage >= 0) begin
         clear = 1'b1;
         tick();
         clear = 1'b0;
         check({name, "/after_clear"}, observed(), '0);
      end else if (abort_at < 0) begin
`ifdef FC_SEQ_PERF_EN
         exp_pass = 32'(sum + N + 1);
`else
         exp_pass = '0;
`endif
      end
      check({name, "/pass_cycles"}, pass_o, exp_pass);
   endtask

   initial begin
      int d[3];
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      clear = 1'b0;
      done_in = '0;
      #12;
      check("reset/outputs", observed(), '0);
      check("reset/pass", pass_o, '0);
      rst = 1'b0;
      tick();

      run_pass("nominal", '{10, 10, 10}, -1, 1'b0, -1);
`ifdef FC_SEQ_PERF_EN
      check("nominal/pass34", pass_o, 32'd34);
`endif
      run_pass("timeout_s1", '{7, 0, 10}, -1, 1'b0, -1);
      run_pass("abort_s1", '{10, 10, 10}, 15, 1'b0, -1);
      run_pass("collide", '{16, 16, 16}, -1, 1'b1, -1);
      run_pass("short", '{1, 1, 1}, -1, 1'b1, -1);
      run_pass("timeout_s0", '{0, 5, 5}, -1, 1'b0, -1);
      run_pass("timeout_s2", '{3, 4, 0}, -1, 1'b0, -1);
      run_pass("reset_s1", '{6, 12, 4}, -1, 1'b0, 11);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("post_reset/idle%0d", i), observed(), '0);
         tick();
      end
      run_pass("clean_after_reset", '{10, 10, 10}, -1, 1'b0, -1);

      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < N; k++) d[k] = int'($urandom_range(1, T));
         if (r % 5 == 4) d[$urandom_range(0, N - 1)] = 0;
         run_pass($sformatf("rand%0d", r), d,
                  (r % 7 == 3) ? int'($urandom_range(0, d[0])) : -1,
                  1'($urandom_range(0, 1)), -1);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fc_seq_ctrl.md
FC_SEQ_CTRL -- requirements
Module: fc_seq_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of sequenced FC/conv datapath stages (stage 0 runs first).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum WAIT cycles per stage before an error is raised.
REQ-003 Parameter STG_W, default 2: width of the stage index, which SHALL be at least clog2(NUM_STAGES).
REQ-004 clk_i  input  1  single rising-edge clock.
REQ-005 rst_i  input  1  asynchronous reset, active-high.
REQ-006 start_i  input  1  one-cycle request to run one full inference pass.
REQ-007 abort_i  input  1  cancels the pass in progress.
REQ-008 clear_i  input  1  clears the sticky error.
REQ-009 stage_done_i  input  NUM_STAGES  per-stage done pulses (bit k from stage k).
REQ-010 stage_start_o  output  NUM_STAGES  one-hot, one-cycle start pulses to the stages.
REQ-011 stage_idx_o  output  STG_W  index of the active stage.
REQ-012 busy_o  output  1  high in any state other than IDLE and ERROR.
REQ-013 done_o  output  1  one-cycle pulse when the pass completes.
REQ-014 error_o  output  1  sticky timeout flag.
REQ-015 err_stage_o  output  STG_W  index of the stage that timed out.
REQ-016 pass_cycles_o  output  32  cycle count of the last completed pass (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT, FINISH and ERROR, encoded in one state register.
REQ-018 IDLE: start_i sampled high SHALL move the FSM to ISSUE with stage=0; start_i SHALL be ignored in every other state, with no queuing.
REQ-019 ISSUE lasts exactly one cycle: stage_start_o[stage]=1 and all other bits 0; the FSM then goes to WAIT and the wait counter is cleared to 0.
REQ-020 Latency from start_i high to stage_start_o[0] high SHALL be 1 cycle; stage_start_o SHALL come from a register.
REQ-021 WAIT: stage_done_i[stage] sampled high SHALL, if stage<NUM_STAGES-1, increment stage and enter ISSUE, so the next stage starts 1 cycle after done.
REQ-022 WAIT: stage_done_i[stage] sampled high with stage=NUM_STAGES-1 SHALL enter FINISH.
REQ-023 stage_done_i bits for non-active stages, and any stage_done_i in IDLE or ISSUE, SHALL be ignored.
REQ-024 FINISH: done_o=1 for exactly one cycle, then the FSM returns to IDLE; a start_i in the FINISH cycle SHALL be ignored.
REQ-025 The wait counter SHALL increment each WAIT cycle; reaching TIMEOUT_CYCLES-1 without the active done SHALL enter ERROR, set error_o=1 and set err_stage_o=stage.
REQ-026 If done and timeout occur in the same cycle, done SHALL win.
REQ-027 ERROR: error_o SHALL stay 1 and start_i SHALL be ignored; clear_i SHALL return the FSM to IDLE and clear error_o and err_stage_o.
REQ-028 abort_i high in ISSUE, WAIT or FINISH SHALL return the FSM to IDLE on the next edge with stage=0, no done_o and no further start pulses; abort_i SHALL be ignored in IDLE and ERROR.
REQ-029 Priority: abort_i > stage done > timeout.
REQ-030 stage_idx_o SHALL equal the stage register at all times; the stage register SHALL reset to 0 and return to 0 on every entry to IDLE.

Reset
REQ-031 rst_i high SHALL asynchronously force: state=IDLE, stage=0, wait counter=0, stage_start_o=0, done_o=0, error_o=0, err_stage_o=0, pass_cycles_o=0.
REQ-032 Reset asserted mid-pass SHALL abort the pass with no done_o; after release the FSM SHALL require a new start_i.

Configuration
REQ-033 Macro FC_SEQ_PERF_EN defined: a 32-bit counter SHALL clear on ISSUE of stage 0, increment every cycle while busy_o=1, saturate at 0xFFFFFFFF, and load into pass_cycles_o in the FINISH cycle; an aborted pass SHALL leave pass_cycles_o unchanged.
REQ-034 Macro FC_SEQ_PERF_EN undefined: no counter logic SHALL be built and pass_cycles_o SHALL be constant 0.

Verification
REQ-035 Nominal pass: start_i; each stage answers with done 10 cycles after its start -> stage_start_o = 001, 010, 100, each 1 cycle after the prior done; done_o 1 cycle after stage-2 done; pass_cycles_o=34 with PERF.
REQ-036 Timeout: TIMEOUT_CYCLES=16; stage 1 never answers -> error_o=1 with err_stage_o=1 after 16 WAIT cycles; start_i ignored; clear_i -> IDLE, error_o=0.
REQ-037 Abort: abort_i during stage-1 WAIT -> IDLE next cycle, stage_idx_o=0, no done_o, no stage_start_o[2], pass_cycles_o unchanged.
REQ-038 Spurious done: stage_done_i[2] during stage-0 WAIT, and stage_done_i[0] in the ISSUE cycle -> no state change.
REQ-039 Collisions: done and timeout in the same cycle -> next stage issued, no error; start_i in the FINISH cycle -> no new pass started.
REQ-040 Reset in stage-1 WAIT -> all outputs 0 immediately; the next start_i runs a full clean pass.
